// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared types and constants for the erosion window sequencer
package morph_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN,
      ST_FLUSH
   } state_t;

   // Pipeline depth of the cross-minimum window, flush pulses per row, dout tag delay
   localparam int WIN_LAT   = 3;
   localparam int FLUSH_LEN = 3;
   localparam int TAG_DLY   = 2;

   typedef struct packed {
      logic v;
      logic sof;
      logic eol;
      logic eof;
   } tag_t;

endpackage

// File: rtl/morph_line_buf.sv
// rtl/morph_line_buf.sv - one-line delay buffer, read-before-write at a circular pointer
module morph_line_buf #(
   parameter int DEPTH = 250,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ptr;

   assign rd_data = mem[ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (we) begin
         if (ptr == AW'(DEPTH - 1)) ptr <= '0;
         else                       ptr <= ptr + 1'b1;
      end
   end

   // Contents are never cleared; a fresh frame's fill rows overwrite them.
   always_ff @(posedge clk) begin
      if (we) mem[ptr] <= wr_data;
   end

endmodule

// File: rtl/morph_win_sched.sv
// rtl/morph_win_sched.sv - raster-to-3x3-window sequencer with flush pulses and dout tagging
module morph_win_sched
   import morph_pkg::*;
#(
   parameter int PIC_WIDTH  = 250,
   parameter int PIC_HEIGHT = 250,
   parameter int WIDTH      = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   input  logic             s_sof,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic             win_valid,
   output logic [WIDTH-1:0] win_din1,
   output logic [WIDTH-1:0] win_din2,
   output logic [WIDTH-1:0] win_din3,
   output logic             m_valid,
   output logic             m_sof,
   output logic             m_eol,
   output logic             m_eof
);

   localparam int CW = $clog2(PIC_WIDTH);
   localparam int RW = $clog2(PIC_HEIGHT);
   localparam int PW = $clog2(PIC_WIDTH + FLUSH_LEN);
   localparam int FW = $clog2(FLUSH_LEN);

   state_t           state, state_nxt;
   logic [CW-1:0]    col, col_nxt;
   logic [RW-1:0]    row, row_nxt;
   logic [FW-1:0]    fcnt, fcnt_nxt;
   logic             acc, last_col, lb_we, run_pulse, flush_pulse, restart;
   logic [PW-1:0]    pidx;
   tag_t             tag_new;
   tag_t             tag_pipe [TAG_DLY];
   logic [WIDTH-1:0] lb1_q, lb2_q;

   assign s_ready  = (state != ST_FLUSH);
   assign acc      = s_valid & s_ready;
   assign last_col = (col == CW'(PIC_WIDTH - 1));

   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      row_nxt     = row;
      fcnt_nxt    = fcnt;
      lb_we       = 1'b0;
      run_pulse   = 1'b0;
      flush_pulse = 1'b0;
      restart     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (acc && s_sof) begin
               restart = 1'b1;
               lb_we   = 1'b1;
            end
         end
         ST_FILL, ST_RUN: begin
            if (acc) begin
               lb_we     = 1'b1;
               run_pulse = (state == ST_RUN) && !s_sof;
               if (s_sof) begin
                  restart = 1'b1;
               end else if (last_col) begin
                  col_nxt = '0;
                  if (state == ST_RUN) begin
                     state_nxt = ST_FLUSH;
                  end else begin
                     row_nxt = row + 1'b1;
                     if (row == RW'(1)) state_nxt = ST_RUN;
                  end
               end else begin
                  col_nxt = col + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            flush_pulse = 1'b1;
            if (fcnt == FW'(FLUSH_LEN - 1)) begin
               fcnt_nxt = '0;
               if (row == RW'(PIC_HEIGHT - 1)) begin
                  row_nxt   = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  row_nxt   = row + 1'b1;
                  state_nxt = ST_RUN;
               end
            end else begin
               fcnt_nxt = fcnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // A start-of-frame pixel always becomes row 0, col 0 of a new fill.
      if (restart) begin
         state_nxt = ST_FILL;
         row_nxt   = '0;
         col_nxt   = CW'(1);
         fcnt_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         col   <= '0;
         row   <= '0;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Pulse index within the row slot; the window's result trails the pulse by WIN_LAT columns.
   always_comb begin
      pidx        = run_pulse ? PW'(col) : (PW'(PIC_WIDTH) + PW'(fcnt));
      tag_new.v   = (run_pulse || flush_pulse) &&
                    (pidx >= PW'(WIN_LAT + 1)) && (pidx <= PW'(PIC_WIDTH - 2 + WIN_LAT));
      tag_new.sof = tag_new.v && (row == RW'(2)) && (pidx == PW'(WIN_LAT + 1));
      tag_new.eol = tag_new.v && (pidx == PW'(PIC_WIDTH - 2 + WIN_LAT));
      tag_new.eof = tag_new.eol && (row == RW'(PIC_HEIGHT - 1));
   end

   morph_line_buf #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH)) u_lb1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (lb_we),
      .wr_data (s_data),
      .rd_data (lb1_q)
   );

   morph_line_buf #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH)) u_lb2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (lb_we),
      .wr_data (lb1_q),
      .rd_data (lb2_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid <= 1'b0;
         win_din1  <= '0;
         win_din2  <= '0;
         win_din3  <= '0;
         for (int i = 0; i < TAG_DLY; i++) tag_pipe[i] <= '0;
      end else begin
         win_valid <= run_pulse | flush_pulse;
         if (run_pulse) begin
            win_din1 <= lb2_q;
            win_din2 <= lb1_q;
            win_din3 <= s_data;
         end else if (flush_pulse) begin
            win_din1 <= '0;
            win_din2 <= '0;
            win_din3 <= '0;
         end
         if (restart) begin
            for (int i = 0; i < TAG_DLY; i++) tag_pipe[i] <= '0;
         end else begin
            tag_pipe[0] <= tag_new;
            for (int i = 1; i < TAG_DLY; i++) tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign m_valid = tag_pipe[TAG_DLY-1].v;
   assign m_sof   = tag_pipe[TAG_DLY-1].sof;
   assign m_eol   = tag_pipe[TAG_DLY-1].eol;
   assign m_eof   = tag_pipe[TAG_DLY-1].eof;

endmodule
